banked_mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 14 +
 rtl/bank_busy_ctr.sv | 56 +++++
 rtl/banked_mem_responder.sv | 86 ++++++++
 tb/tb_banked_mem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and bank-state encoding for the banked memory responder.
package mem_pkg;
    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 16;
    localparam int NUM_BANKS    = 4;
    localparam int BANK_SEL_LSB = 1;
    localparam int BANK_SEL_MSB = 2;
    localparam int BANK_SEL_W   = BANK_SEL_MSB - BANK_SEL_LSB + 1;

    typedef enum logic {
        BANK_IDLE = 1'b0,
        BANK_BUSY = 1'b1
    } bank_state_e;
endpackage

// File: rtl/bank_busy_ctr.sv
// Per-bank occupancy tracker: loads BANK_LAT on accept and counts down to idle.
module bank_busy_ctr
    import mem_pkg::*;
#(
    parameter int BANK_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);
    localparam int CNT_W = $clog2(BANK_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bank_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BANK_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Load is only honoured in IDLE; the last busy cycle is the one with cnt==1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            BANK_IDLE: begin
                if (load) begin
                    state_nxt = BANK_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BANK_BUSY: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt <= CNT_ONE) begin
                    state_nxt = BANK_IDLE;
                end
            end
            default: begin
                state_nxt = BANK_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state == BANK_BUSY);
    end
endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved pipelined memory model with per-bank busy and fixed read latency.
module banked_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W   = mem_pkg::ADDR_W,
    parameter int DATA_W   = mem_pkg::DATA_W,
    parameter int MEM_AW   = 12,
    parameter int BANK_LAT = 4,
    parameter int READ_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 wr,
    input  logic                 rd,
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid_out,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);
    logic [BANK_SEL_W-1:0] bank_sel;
    logic [MEM_AW-1:0]     word_idx;
    logic                  req;
    logic                  accept;
    logic [NUM_BANKS-1:0]  bank_load;
    logic                  unused_addr_hi;

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    // Upper address bits alias onto the storage; they intentionally feed nothing.
    assign unused_addr_hi = ^addr[ADDR_W-1:MEM_AW+1];

    assign bank_sel = addr[BANK_SEL_MSB:BANK_SEL_LSB];
    assign word_idx = addr[MEM_AW:1];
    assign err      = (wr & rd) | ((wr | rd) & addr[0]);
    assign req      = (wr ^ rd) & ~addr[0];
    assign stall    = req & busy[bank_sel];
    assign accept   = req & ~busy[bank_sel];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_load[b] = accept & (bank_sel == BANK_SEL_W'(b));

        bank_busy_ctr #(
            .BANK_LAT(BANK_LAT)
        ) u_ctr (
            .clk (clk),
            .rst (rst),
            .load(bank_load[b]),
            .busy(busy[b])
        );
    end

    // Storage is not reset so committed writes survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (accept & wr) begin
            mem[word_idx] <= data_in;
        end
    end

    // Read pipeline: stage 0 captures at acceptance, output at stage READ_LAT-1.
    logic [DATA_W-1:0]   rd_data_p [READ_LAT];
    logic [READ_LAT-1:0] vld_p;

    always_ff @(posedge clk) begin
        rd_data_p[0] <= mem[word_idx];
        for (int i = 1; i < READ_LAT; i++) begin
            rd_data_p[i] <= rd_data_p[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= accept & rd;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign valid_out = vld_p[READ_LAT-1];
    assign data_out  = valid_out ? rd_data_p[READ_LAT-1] : '0;
endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench for banked_mem_responder: cycle-table vectors plus hand-written corner sequences.
module tb_banked_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        valid_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    banked_mem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .valid_out(valid_out),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic        r;
        logic [15:0] a;
        logic [15:0] d;
        logic [3:0]  e_busy;
        logic        e_stall;
        logic        e_err;
        logic        e_vld;
        logic [15:0] e_dout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic w, logic r, logic [15:0] a, logic [15:0] d,
                                logic [3:0] eb, logic es, logic ee, logic ev, logic [15:0] ed);
        vec_t v;
        v.w = w; v.r = r; v.a = a; v.d = d;
        v.e_busy = eb; v.e_stall = es; v.e_err = ee; v.e_vld = ev; v.e_dout = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        wr = w; rd = r; addr = a; data_in = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic read_expect(input string name, input logic [15:0] a, input logic [15:0] exp);
        cyc(1'b0, 1'b1, a, 16'h0000);
        chk({name, "_stall"}, stall, 1'b0);
        idle(1);
        chk({name, "_vld_early"}, valid_out, 1'b0);
        idle(1);
        chk({name, "_vld"}, valid_out, 1'b1);
        chk({name, "_data"}, data_out, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        logic accepted;

        rst = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 4'b0000);
        chk("rst_stall", stall, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_vld", valid_out, 1'b0);
        chk("rst_dout", data_out, 16'h0000);
        rst = 1'b1;

        // Write/read, preload of four banks, then interleaved reads.
        vecs.push_back(mk(1,0,16'h0008,16'h1234, 4'b0000,0,0,0,16'h0000));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b0001,0,0,0,16'h0000));
        vecs.push_back(mk(0,1,16'h0008,16'h0000, 4'b0000,0,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b0001,0,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b0001,0,0,1,16'h1234));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b0001,0,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b0001,0,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,16'h00A0, 4'b0000,0,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0002,16'h00A1, 4'b0001,0,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0004,16'h00A2, 4'b0011,0,0,0,16'h0000));
        vecs.push_back(mk(1,0,16'h0006,16'h00A3, 4'b0111,0,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b1111,0,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b1110,0,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b1100,0,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b1000,0,0,0,16'h0000));
        vecs.push_back(mk(0,1,16'h0000,16'h0000, 4'b0000,0,0,0,16'h0000));
        vecs.push_back(mk(0,1,16'h0002,16'h0000, 4'b0001,0,0,0,16'h0000));
        vecs.push_back(mk(0,1,16'h0004,16'h0000, 4'b0011,0,0,1,16'h00A0));
        vecs.push_back(mk(0,1,16'h0006,16'h0000, 4'b0111,0,0,1,16'h00A1));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b1111,0,0,1,16'h00A2));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b1110,0,0,1,16'h00A3));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b1100,0,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b1000,0,0,0,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,16'h0000, 4'b0000,0,0,0,16'h0000));

        foreach (vecs[i]) begin
            cyc(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("vec%0d_err", i), err, vecs[i].e_err);
            chk($sformatf("vec%0d_vld", i), valid_out, vecs[i].e_vld);
            chk($sformatf("vec%0d_dout", i), data_out, vecs[i].e_dout);
        end

        // Same-bank conflict: read held while the bank drains.
        cyc(1'b1, 1'b0, 16'h0008, 16'hBEEF);
        stalls = 0;
        accepted = 1'b0;
        for (int k = 0; k < 10 && !accepted; k++) begin
            cyc(1'b0, 1'b1, 16'h0008, 16'h0000);
            if (stall) stalls++;
            else accepted = 1'b1;
        end
        chk("conflict_stall_cycles", stalls, 4);
        chk("conflict_accepted", accepted, 1'b1);
        idle(1);
        chk("conflict_vld_early", valid_out, 1'b0);
        idle(1);
        chk("conflict_vld", valid_out, 1'b1);
        chk("conflict_data", data_out, 16'hBEEF);
        idle(4);

        // Errors: both strobes, and a misaligned read.
        cyc(1'b1, 1'b0, 16'h0010, 16'h7777);
        idle(5);
        cyc(1'b1, 1'b1, 16'h0010, 16'hDEAD);
        chk("err_both", err, 1'b1);
        chk("err_both_stall", stall, 1'b0);
        idle(1);
        chk("err_both_busy", busy, 4'b0000);
        chk("err_clear", err, 1'b0);
        read_expect("err_mem_kept", 16'h0010, 16'h7777);
        idle(4);
        cyc(1'b0, 1'b1, 16'h0003, 16'h0000);
        chk("err_odd", err, 1'b1);
        chk("err_odd_stall", stall, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk($sformatf("err_odd_vld%0d", k), valid_out, 1'b0);
            chk($sformatf("err_odd_busy%0d", k), busy, 4'b0000);
        end

        // Reset while a read is in flight.
        cyc(1'b1, 1'b0, 16'h0008, 16'h4242);
        idle(5);
        cyc(1'b0, 1'b1, 16'h0008, 16'h0000);
        chk("rstmid_accept", stall, 1'b0);
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0;
        rst = 1'b0;
        #1;
        chk("rstmid_busy", busy, 4'b0000);
        chk("rstmid_vld", valid_out, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        chk("rstmid_vld_c2", valid_out, 1'b0);
        chk("rstmid_dout_c2", data_out, 16'h0000);
        idle(1);
        chk("rstmid_vld_c3", valid_out, 1'b0);
        read_expect("rstmid_reread", 16'h0008, 16'h4242);
        idle(4);

        // Upper address bits alias onto the same word.
        cyc(1'b1, 1'b0, 16'h2008, 16'h5555);
        idle(1);
        chk("wrap_busy", busy, 4'b0001);
        idle(4);
        read_expect("wrap", 16'h0008, 16'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
